// File: rtl/uart_rx_packet_deframer.sv
// uart_rx_packet_deframer
//   Receives 8N1 UART bytes and parses host packets of the form
//   [HEADER | NOC_ADDR | SIZE_LO | SIZE_HI | PAYLOAD(SIZE bytes)].
//   The payload is repacked into little-endian DATA_WIDTH flits on a
//   valid/ready stream. The header fields are presented alongside the stream.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-high reset
//   rx_serial    UART line, idle high, asynchronous to clock
//   out_valid    flit available; held stable until accepted
//   out_ready    consumer accepts when out_valid && out_ready at posedge
//   out_data     flit, first payload byte in [7:0]
//   out_first    flit is the first of its packet
//   out_last     flit contains the final payload byte
//   pkt_type     HEADER byte of the current packet
//   pkt_addr     NOC_ADDR byte of the current packet
//   pkt_size     SIZE field of the current packet, in bytes
//   pkt_start    pulse once SIZE has been received
//   pkt_done     pulse when the last flit is accepted (or with pkt_start if SIZE==0)
//   frame_err    pulse: stop bit sampled low
//   overrun_err  pulse: flit completed while the previous one was still pending
//   timeout_err  pulse: inter-byte gap inside a packet exceeded TIMEOUT_CYCLES
module uart_rx_packet_deframer #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 86800
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_serial,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic [7:0]            pkt_type,
  output logic [7:0]            pkt_addr,
  output logic [15:0]           pkt_size,
  output logic                  pkt_start,
  output logic                  pkt_done,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  timeout_err
);

  localparam int BPF       = DATA_WIDTH / 8;
  localparam int LANE_W    = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int BIT_CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HALF_BIT  = CLKS_PER_BIT / 2;

  // ---------------------------------------------------------------------
  // Two-flop synchroniser; idles high so reset does not look like a start bit
  // ---------------------------------------------------------------------
  logic rx_meta_reg, rx_sync_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx_serial;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // ---------------------------------------------------------------------
  // UART receiver FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

  rx_state_t              rx_state_reg, rx_state_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [2:0]             bit_idx_reg, bit_idx_next;
  logic [7:0]             rx_shift_reg, rx_shift_next;
  logic                   byte_strobe_reg, byte_strobe_next;
  logic                   frame_err_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_reg    <= R_IDLE;
      bit_cnt_reg     <= '0;
      bit_idx_reg     <= '0;
      rx_shift_reg    <= '0;
      byte_strobe_reg <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      rx_state_reg    <= rx_state_next;
      bit_cnt_reg     <= bit_cnt_next;
      bit_idx_reg     <= bit_idx_next;
      rx_shift_reg    <= rx_shift_next;
      byte_strobe_reg <= byte_strobe_next;
      frame_err       <= frame_err_next;
    end
  end

  always_comb begin
    rx_state_next    = rx_state_reg;
    bit_cnt_next     = bit_cnt_reg + 1'b1;
    bit_idx_next     = bit_idx_reg;
    rx_shift_next    = rx_shift_reg;
    byte_strobe_next = 1'b0;
    frame_err_next   = 1'b0;
    case (rx_state_reg)
      R_IDLE: begin
        bit_cnt_next = '0;
        if (!rx_sync_reg) rx_state_next = R_START;
      end
      R_START: begin
        // Re-check the start bit at mid-bit; a line that is high again was a glitch.
        if (bit_cnt_reg == BIT_CNT_W'(HALF_BIT - 1)) begin
          bit_cnt_next  = '0;
          bit_idx_next  = '0;
          rx_state_next = rx_sync_reg ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (bit_cnt_reg == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_next  = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};  // LSB arrives first
          bit_idx_next  = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) rx_state_next = R_STOP;
        end
      end
      R_STOP: begin
        if (bit_cnt_reg == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_next = '0;
          if (rx_sync_reg) begin
            byte_strobe_next = 1'b1;
            rx_state_next    = R_IDLE;
          end else begin
            frame_err_next = 1'b1;
            rx_state_next  = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        // Do not hunt for a new start bit until the line has recovered.
        bit_cnt_next = '0;
        if (rx_sync_reg) rx_state_next = R_IDLE;
      end
      default: rx_state_next = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Packet parser FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {P_HDR, P_ADDR, P_SZLO, P_SZHI, P_DATA} p_state_t;

  p_state_t              p_state_reg, p_state_next;
  logic [7:0]            hdr_shadow_reg, addr_shadow_reg, szlo_shadow_reg;
  logic [15:0]           byte_cnt_reg;
  logic [LANE_W-1:0]     lane_reg;
  logic [DATA_WIDTH-1:0] word_reg;
  logic                  first_flag_reg;
  logic [GAP_W-1:0]      gap_cnt_reg;
  logic                  flit_valid_reg, flit_first_reg, flit_last_reg;
  logic [DATA_WIDTH-1:0] flit_data_reg;

  logic [15:0]           size_full;
  logic                  lane_last, is_final, timeout_hit, size_zero_hit, data_strobe;
  logic [DATA_WIDTH-1:0] word_merged;

  assign size_full     = {rx_shift_reg, szlo_shadow_reg};
  assign lane_last     = (lane_reg == LANE_W'(BPF - 1));
  assign is_final      = (byte_cnt_reg + 16'd1 == pkt_size);
  assign data_strobe   = byte_strobe_reg && (p_state_reg == P_DATA);
  assign size_zero_hit = byte_strobe_reg && (p_state_reg == P_SZHI) && (size_full == 16'd0);
  assign timeout_hit   = (p_state_reg != P_HDR) && !byte_strobe_reg &&
                         (gap_cnt_reg == GAP_W'(TIMEOUT_CYCLES - 1));

  // Drop the received byte into its lane without a variable shifter.
  generate
    for (genvar gi = 0; gi < BPF; gi++) begin : g_lane
      assign word_merged[gi*8 +: 8] = (lane_reg == LANE_W'(gi)) ? rx_shift_reg
                                                                 : word_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    p_state_next = p_state_reg;
    if (byte_strobe_reg) begin
      case (p_state_reg)
        P_HDR:   p_state_next = P_ADDR;
        P_ADDR:  p_state_next = P_SZLO;
        P_SZLO:  p_state_next = P_SZHI;
        P_SZHI:  p_state_next = (size_full == 16'd0) ? P_HDR : P_DATA;
        P_DATA:  if (is_final) p_state_next = P_HDR;
        default: p_state_next = P_HDR;
      endcase
    end
    if (timeout_hit) p_state_next = P_HDR;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_state_reg     <= P_HDR;
      hdr_shadow_reg  <= '0;
      addr_shadow_reg <= '0;
      szlo_shadow_reg <= '0;
      byte_cnt_reg    <= '0;
      lane_reg        <= '0;
      word_reg        <= '0;
      first_flag_reg  <= 1'b0;
      gap_cnt_reg     <= '0;
      flit_valid_reg  <= 1'b0;
      flit_first_reg  <= 1'b0;
      flit_last_reg   <= 1'b0;
      flit_data_reg   <= '0;
      pkt_type        <= '0;
      pkt_addr        <= '0;
      pkt_size        <= '0;
      pkt_start       <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      p_state_reg    <= p_state_next;
      pkt_start      <= 1'b0;
      timeout_err    <= 1'b0;
      flit_valid_reg <= 1'b0;

      if (byte_strobe_reg || p_state_reg == P_HDR || timeout_hit) gap_cnt_reg <= '0;
      else                                                         gap_cnt_reg <= gap_cnt_reg + 1'b1;

      if (timeout_hit) begin
        timeout_err <= 1'b1;
        word_reg    <= '0;
        lane_reg    <= '0;
      end

      if (byte_strobe_reg) begin
        case (p_state_reg)
          P_HDR:  hdr_shadow_reg  <= rx_shift_reg;
          P_ADDR: addr_shadow_reg <= rx_shift_reg;
          P_SZLO: szlo_shadow_reg <= rx_shift_reg;
          P_SZHI: begin
            // Header fields become visible together, only once SIZE is complete.
            pkt_type       <= hdr_shadow_reg;
            pkt_addr       <= addr_shadow_reg;
            pkt_size       <= size_full;
            pkt_start      <= 1'b1;
            byte_cnt_reg   <= '0;
            lane_reg       <= '0;
            word_reg       <= '0;
            first_flag_reg <= 1'b1;
          end
          default: ;
        endcase
      end

      if (data_strobe) begin
        byte_cnt_reg <= byte_cnt_reg + 16'd1;
        if (lane_last || is_final) begin
          flit_valid_reg <= 1'b1;
          flit_data_reg  <= word_merged;
          flit_first_reg <= first_flag_reg;
          flit_last_reg  <= is_final;
          first_flag_reg <= 1'b0;
          word_reg       <= '0;
          lane_reg       <= '0;
        end else begin
          word_reg <= word_merged;
          lane_reg <= lane_reg + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------
  logic accept;
  assign accept = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      pkt_done    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      pkt_done    <= size_zero_hit || (accept && out_last);
      if (flit_valid_reg) begin
        // A stalled flit wins; the newly completed one is dropped.
        if (out_valid && !out_ready) begin
          overrun_err <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_data  <= flit_data_reg;
          out_first <= flit_first_reg;
          out_last  <= flit_last_reg;
        end
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_deframer.sv
module tb_uart_rx_packet_deframer;

  localparam int CPB = 8;
  localparam int DW  = 32;
  localparam int TO  = 400;
  localparam int BPF = DW / 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_serial = 1'b1;
  logic          out_ready;
  logic          out_valid, out_first, out_last;
  logic [DW-1:0] out_data;
  logic [7:0]    pkt_type, pkt_addr;
  logic [15:0]   pkt_size;
  logic          pkt_start, pkt_done, frame_err, overrun_err, timeout_err;

  uart_rx_packet_deframer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .rx_serial(rx_serial),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last),
    .pkt_type(pkt_type), .pkt_addr(pkt_addr), .pkt_size(pkt_size),
    .pkt_start(pkt_start), .pkt_done(pkt_done), .frame_err(frame_err),
    .overrun_err(overrun_err), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done = 0, n_frame = 0, n_overrun = 0, n_timeout = 0, n_start = 0, n_valid_cyc = 0;
  int exp_done = 0;
  int ready_mode = 1;
  bit mon_en = 1'b1;

  logic [DW+1:0] exp_flits[$];   // {first, last, data}
  logic [31:0]   exp_hdr[$];     // {type, addr, size}
  logic [7:0]    pay[64];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the payload cut into BPF-byte little-endian flits.
  task automatic expect_packet(input logic [7:0] t, input logic [7:0] a, input int size,
                               input bit model_flits);
    logic [DW-1:0] w;
    exp_hdr.push_back({t, a, 16'(size)});
    if (model_flits) begin
      for (int i = 0; i < size; i += BPF) begin
        w = '0;
        for (int j = 0; j < BPF; j++)
          if (i + j < size) w[8*j +: 8] = pay[i+j];
        exp_flits.push_back({(i == 0), (i + BPF >= size), w});
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    @(negedge clock) rx_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx_serial = stop_ok;
    repeat (CPB) @(negedge clock);
    rx_serial = 1'b1;
    repeat (2*CPB) @(negedge clock);
  endtask

  task automatic send_packet(input logic [7:0] t, input logic [7:0] a, input int size,
                             input int nbytes, input bit model_flits);
    expect_packet(t, a, size, model_flits);
    send_byte(t);
    send_byte(a);
    send_byte(size[7:0]);
    send_byte(size[15:8]);
    for (int i = 0; i < nbytes; i++) send_byte(pay[i]);
  endtask

  task automatic set_t1_payload();
    pay[0] = 8'h04; pay[1] = 8'h03; pay[2] = 8'h02; pay[3] = 8'h01;
    pay[4] = 8'h08; pay[5] = 8'h07; pay[6] = 8'h06; pay[7] = 8'h05;
  endtask

  // out_ready changes just after posedge so it is stable when sampled at negedge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: counts pulses, checks header fields and every accepted flit.
  always @(negedge clock) begin
    if (!reset) begin
      if (pkt_done)    n_done++;
      if (frame_err)   n_frame++;
      if (overrun_err) n_overrun++;
      if (timeout_err) n_timeout++;
      if (out_valid)   n_valid_cyc++;
      if (pkt_start) begin
        n_start++;
        check("hdr_expected", exp_hdr.size() > 0, 1);
        if (exp_hdr.size() > 0) begin
          logic [31:0] h;
          h = exp_hdr.pop_front();
          check("pkt_type", pkt_type, h[31:24]);
          check("pkt_addr", pkt_addr, h[23:16]);
          check("pkt_size", pkt_size, h[15:0]);
          check("done_with_start", pkt_done, h[15:0] == 16'd0);
        end
      end
      if (mon_en && out_valid && out_ready) begin
        check("flit_expected", exp_flits.size() > 0, 1);
        if (exp_flits.size() > 0) begin
          logic [DW+1:0] f;
          f = exp_flits.pop_front();
          check("flit", {out_first, out_last, out_data}, f);
        end
      end
    end
  end

  initial begin
    int base_v, base_f, base_o, base_t, sz;

    // Reset state
    repeat (4) @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_hdr", {pkt_type, pkt_addr, pkt_size}, 0);
    check("rst_pulses", {out_first, out_last, pkt_start, pkt_done, frame_err, overrun_err, timeout_err}, 0);
    reset = 1'b0;
    repeat (4*CPB) @(negedge clock);

    // T1: two full flits
    set_t1_payload();
    send_packet(8'h03, 8'h08, 8, 8, 1);
    repeat (4*CPB) @(negedge clock);
    exp_done++;
    check("t1_done", n_done, exp_done);
    check("t1_flits_left", exp_flits.size(), 0);

    // T2: partial last flit, upper lanes zero
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC; pay[3] = 8'hDD; pay[4] = 8'hEE;
    send_packet(8'h01, 8'h05, 5, 5, 1);
    repeat (4*CPB) @(negedge clock);
    exp_done++;
    check("t2_done", n_done, exp_done);
    check("t2_flits_left", exp_flits.size(), 0);

    // T3: empty packet
    base_v = n_valid_cyc;
    send_packet(8'h00, 8'h02, 0, 0, 1);
    repeat (4*CPB) @(negedge clock);
    exp_done++;
    check("t3_done", n_done, exp_done);
    check("t3_no_valid", n_valid_cyc, base_v);

    // T4: consumer stalled, second flit overruns
    ready_mode = 0;
    mon_en = 1'b0;
    base_o = n_overrun;
    repeat (4) @(negedge clock);
    set_t1_payload();
    send_packet(8'h03, 8'h08, 8, 8, 0);
    repeat (4*CPB) @(negedge clock);
    check("t4_overrun", n_overrun, base_o + 1);
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, 32'h01020304);
    check("t4_first_last", {out_first, out_last}, 2'b10);
    check("t4_no_done", n_done, exp_done);
    ready_mode = 1;
    repeat (4) @(negedge clock);
    check("t4_drained", out_valid, 0);
    check("t4_still_no_done", n_done, exp_done);
    mon_en = 1'b1;

    // T5: framing error and a start-bit glitch inside a packet are ignored
    base_f = n_frame;
    pay[0] = 8'h11; pay[1] = 8'h22;
    expect_packet(8'h03, 8'h08, 2, 1);
    send_byte(8'h03);
    send_byte(8'h55, 1'b0);
    @(negedge clock) rx_serial = 1'b0;
    repeat (2) @(negedge clock);
    rx_serial = 1'b1;
    repeat (2*CPB) @(negedge clock);
    send_byte(8'h08);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (4*CPB) @(negedge clock);
    exp_done++;
    check("t5_frame_err", n_frame, base_f + 1);
    check("t5_done", n_done, exp_done);
    check("t5_flits_left", exp_flits.size(), 0);

    // T6: inter-byte timeout, then a clean packet
    base_t = n_timeout;
    base_v = n_valid_cyc;
    set_t1_payload();
    send_packet(8'h03, 8'h08, 8, 1, 0);
    repeat (TO + 100) @(negedge clock);
    check("t6_timeout", n_timeout, base_t + 1);
    check("t6_no_flit", n_valid_cyc, base_v);
    send_packet(8'h03, 8'h08, 8, 8, 1);
    repeat (4*CPB) @(negedge clock);
    exp_done++;
    check("t6_done", n_done, exp_done);
    check("t6_flits_left", exp_flits.size(), 0);

    // Random packets with random back-pressure
    ready_mode = 2;
    for (int k = 0; k < 6; k++) begin
      sz = $urandom_range(0, 11);
      for (int i = 0; i < sz; i++) pay[i] = 8'($urandom);
      send_packet(8'($urandom), 8'($urandom), sz, sz, 1);
      repeat (6*CPB) @(negedge clock);
      exp_done++;
      check("rnd_done", n_done, exp_done);
      check("rnd_flits_left", exp_flits.size(), 0);
    end
    check("err_totals", {n_frame[7:0], n_overrun[7:0], n_timeout[7:0]}, 24'h010101);
    check("hdr_left", exp_hdr.size(), 0);

    // Reset in mid-payload with a flit pending
    ready_mode = 0;
    mon_en = 1'b0;
    repeat (4) @(negedge clock);
    set_t1_payload();
    send_packet(8'h07, 8'h09, 8, 5, 0);
    repeat (2*CPB) @(negedge clock);
    check("rst_pre_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_data", out_data, 0);
    check("rst_mid_hdr", {pkt_type, pkt_addr, pkt_size}, 0);
    check("rst_mid_pulses", {out_first, out_last, pkt_start, pkt_done, frame_err, overrun_err, timeout_err}, 0);
    repeat (4) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
